pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised pipelined ripple-carry adder/subtractor; next generation of the 1-bit full adder.
//   Splits a WIDTH-bit add/sub into STAGES carry-chained slices, one register stage per slice.
//   Uses a valid/ready handshake with full throughput: one operation per cycle, with backpressure.
//   Sits between operand producers and ALU/accumulator consumers. Carry/borrow in/out allows chaining.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 (elaboration error otherwise)
//   STAGES  4   pipeline depth = number of carry slices; SLICE = WIDTH/STAGES bits per slice; 1..WIDTH
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block accepts beat this cycle
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_cin     in   1      carry-in (add) / borrow-in (sub)
//   in_sub     in   1      0: A+B+cin; 1: A-B-borrow
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  result, modulo 2^WIDTH
//   out_cout   out  1      carry-out (add) / borrow-out (sub)
//   out_ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//   - Reset (async on rst_n low, release synchronous to clk): all stage valid bits 0, all data regs 0.
//     Hence out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 from the first cycle after release.
//   - Transfer occurs when valid&&ready on a given interface in the same cycle.
//   - Stage k (0..STAGES-1) holds valid_k, sum slices 0..k, carry c_k, sub flag, and pending slices k+1.. of A and B'.
//   - Input mapping at accept: B' = in_sub ? ~in_b : in_b; c_in_eff = in_sub ? ~in_cin : in_cin.
//   - Stage 0 computes slice 0 = A[S-1:0]+B'[S-1:0]+c_in_eff. Stage k adds slice k plus carry c_{k-1}.
//   - Last stage drives the outputs:
//     out_cout = in_sub ? ~c_last : c_last
//     out_ovf = carry into MSB XOR carry out of MSB (raw carries, before the sub inversion)
//   - Advance rule: ready_k = ~valid_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
//     Stage k loads from k-1 when ready_k; valid_k <= valid_{k-1} (stage 0: in_valid).
//     Ready is a combinational chain: no bubbles, no skid buffer.
//   - Latency: accept at edge N gives out_valid at edge N+STAGES-1, i.e. STAGES register stages.
//     Throughput 1/cycle while out_ready=1.
//   - Backpressure: with out_ready=0 and the pipe full, in_ready=0 and every stage holds its data stable.
//     A held out_valid/out_sum never changes until accepted.
//   - Bubbles collapse: an empty stage accepts even when downstream is stalled.
//   - Simultaneous accept at both ends while full: shift by one; no loss or duplication.
//   - Registers with valid_k=0 may hold stale data, but output regs are cleared only by reset.
//     out_sum is undefined-but-stable when out_valid=0.
//   - Reset mid-operation: all in-flight beats are discarded; nothing is emitted after release.
//   - STAGES=1: single register stage, 1-cycle latency, same handshake.
//   - Order is strictly FIFO; there is no internal state beyond the pipeline registers.
// STRUCTURE
//   - Shared package addsub_pkg: localparam/function for SLICE=WIDTH/STAGES; MODE_ADD=1'b0, MODE_SUB=1'b1.
//   - Sub-module addsub_slice (param SLICE): combinational SLICE-bit ripple add.
//     Outputs sum, carry out, and carry into the slice MSB (for ovf). One instance per stage via generate.
//   - Top holds the stage registers, ready chain and sub/borrow mapping.
// TESTING
//   Configs: WIDTH=8/STAGES=2, WIDTH=32/STAGES=4, WIDTH=8/STAGES=1.
//   1 Add: 8/2, A=0x7F, B=0x01, cin=0, sub=0 -> 2 cycles later sum=0x80, cout=0, ovf=1.
//     Also A=0xFF, B=0x01 -> sum=0x00, cout=1, ovf=0.
//   2 Sub: A=0x05, B=0x07, sub=1, cin=0 -> sum=0xFE, cout(borrow)=1, ovf=0.
//     A=0x80, B=0x01 -> sum=0x7F, borrow=0, ovf=1.
//   3 Chaining: 32/4; 64-bit 0x00000001_FFFFFFFF + 1 as two beats, cout of beat 1 fed to cin of beat 2.
//     -> 0x00000000 then 0x00000002.
//   4 Throughput/backpressure: stream 100 random beats, out_ready random 50%.
//     -> results in order, match the reference model, no drops/duplicates.
//     Each held output stable; out_ready=1 gives 1 result/cycle.
//   5 Full stall: out_ready=0 for 10 cycles while in_valid=1.
//     -> exactly STAGES beats accepted, then in_ready=0; release gives in-order drain.
//   6 Reset mid-stream: assert rst_n=0 with the pipe full.
//     -> out_valid=0 and outputs 0 immediately (async); no stale beat after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// No timing of its own.
// No handshake of its own.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry slice: SLICE-bit ripple add with carry in and carry out.
// Purely combinational, no latency.
// No handshake; the owning pipeline stage decides when to capture.
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SLICE];
  // Carry into the top bit of the slice, used for signed overflow.
  assign cmsb = c[SLICE-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/sub split into STAGES carry-chained slices.
// Latency STAGES register stages; one result per cycle when unstalled.
// Combinational ready chain; a stalled full pipe holds every stage, bubbles collapse.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Subtraction is A + ~B + ~borrow; the mapping happens once, at accept.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = (in_sub == MODE_SUB) ? ~in_b : in_b;
  assign cin_eff = (in_sub == MODE_SUB) ? ~in_cin : in_cin;

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~vld[k] | rdy[k+1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - k * SLICE;  // operand bits still to be added, incl. this slice
    localparam int HI  = (k + 1) * SLICE;    // result bits known after this stage

    logic             vld_in, sub_in, c_in, c_out, c_msb;
    logic [REM-1:0]   a_src, b_src;
    logic [HI-1:0]    sum_d;
    logic [SLICE-1:0] s_s;

    if (k == 0) begin : g_src
      assign vld_in = in_valid;
      assign sub_in = in_sub;
      assign c_in   = cin_eff;
      assign a_src  = in_a;
      assign b_src  = b_eff;
      assign sum_d  = s_s;
    end else begin : g_src
      assign vld_in = vld[k-1];
      assign sub_in = g_st[k-1].g_reg.sub_q;
      assign c_in   = g_st[k-1].g_reg.c_q;
      assign a_src  = g_st[k-1].g_reg.a_q;
      assign b_src  = g_st[k-1].g_reg.b_q;
      assign sum_d  = {s_s, g_st[k-1].g_reg.sum_q};
    end

    addsub_slice #(.SLICE(SLICE)) u_slice (
      .a    (a_src[SLICE-1:0]),
      .b    (b_src[SLICE-1:0]),
      .cin  (c_in),
      .sum  (s_s),
      .cout (c_out),
      .cmsb (c_msb)
    );

    if (k == STAGES - 1) begin : g_reg
      logic          vld_q, cout_q, ovf_q;
      logic [HI-1:0] sum_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (rdy[k]) begin
          vld_q <= vld_in;
          if (vld_in) begin
            sum_q  <= sum_d;
            cout_q <= (sub_in == MODE_ADD) ? c_out : ~c_out;
            ovf_q  <= c_out ^ c_msb;
          end
        end
      end

      assign vld[k]   = vld_q;
      assign out_sum  = sum_q;
      assign out_cout = cout_q;
      assign out_ovf  = ovf_q;
    end else begin : g_reg
      localparam int PW = REM - SLICE;
      logic          vld_q, c_q, sub_q;
      logic [HI-1:0] sum_q;
      logic [PW-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          sum_q <= '0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          sub_q <= 1'b0;
        end else if (rdy[k]) begin
          vld_q <= vld_in;
          if (vld_in) begin
            sum_q <= sum_d;
            a_q   <= a_src[REM-1:SLICE];
            b_q   <= b_src[REM-1:SLICE];
            c_q   <= c_out;
            sub_q <= sub_in;
          end
        end
      end

      assign vld[k] = vld_q;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 32/4, 8/2 and 8/1 instances against an arithmetic reference.
// Directed corner cases, random streams with backpressure, full stall and mid-stream reset.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      iv, ordy, icin, isub;
  logic [2:0][31:0] ia, ib;
  wire  [2:0]      ir, ov, oc, oo;
  wire  [31:0]     os0;
  wire  [7:0]      os1, os2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [33:0] expq [3][$];
  logic [2:0]  held;
  logic [33:0] heldv [3];

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_w32s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .in_cin(icin[0]), .in_sub(isub[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(os0), .out_cout(oc[0]), .out_ovf(oo[0]));

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_w8s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_cin(icin[1]), .in_sub(isub[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(os1), .out_cout(oc[1]), .out_ovf(oo[1]));

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_w8s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2][7:0]), .in_b(ib[2][7:0]), .in_cin(icin[2]), .in_sub(isub[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(os2), .out_cout(oc[2]), .out_ovf(oo[2]));

  function automatic int wof(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic int sof(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [33:0] obs(input int i);
    case (i)
      0:       return {oo[0], oc[0], os0};
      1:       return {oo[1], oc[1], 24'd0, os1};
      default: return {oo[2], oc[2], 24'd0, os2};
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [33:0] model(input int i, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    int     w    = wof(i);
    longint one  = 1;
    longint mask = (one << w) - 1;
    longint half = one << (w - 1);
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint sa   = (ua >= half) ? ua - (one << w) : ua;
    longint sb   = (ub >= half) ? ub - (one << w) : ub;
    longint r, sr;
    logic   cout, ovf;
    logic [63:0] rs;
    if (!sub) begin
      r    = ua + ub + longint'(cin);
      cout = ((r >> w) & 1) != 0;
      sr   = sa + sb + longint'(cin);
    end else begin
      r    = ua - ub - longint'(cin);
      cout = (r < 0);
      sr   = sa - sb - longint'(cin);
    end
    ovf = (sr > half - 1) || (sr < -half);
    rs  = 64'(r & mask);
    return {ovf, cout, rs[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard and hold-stability monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        held[i] = 1'b0;
      end else begin
        if (held[i]) begin
          chk("hold_vld", 64'(ov[i]), 64'd1);
          chk("hold_dat", 64'(obs(i)), 64'(heldv[i]));
        end
        if (ov[i] && ordy[i]) begin
          if (expq[i].size() == 0) chk("spurious", 64'd1, 64'd0);
          else chk("result", 64'(obs(i)), 64'(expq[i].pop_front()));
        end
        if (iv[i] && ir[i]) expq[i].push_back(model(i, ia[i], ib[i], icin[i], isub[i]));
        held[i]  = ov[i] && !ordy[i];
        heldv[i] = obs(i);
      end
    end
  end

  task automatic new_data(input int i);
    ia[i]   = $urandom;
    ib[i]   = $urandom;
    icin[i] = 1'($urandom_range(1));
    isub[i] = 1'($urandom_range(1));
  endtask

  task automatic one_shot(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    ia[i] = a; ib[i] = b; icin[i] = cin; isub[i] = sub; iv[i] = 1'b1; ordy[i] = 1'b1;
    @(negedge clk);
    chk("os_accept", 64'(ir[i]), 64'd1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
    if (sof(i) > 1) begin
      @(negedge clk);
      chk("os_early", 64'(ov[i]), 64'd0);
      repeat (sof(i) - 1) @(posedge clk);
    end
    @(negedge clk);
    chk("os_vld", 64'(ov[i]), 64'd1);
    chk("os_sum", 64'(obs(i) & 34'hFFFFFFFF), 64'(es));
    chk("os_cout", 64'(oc[i]), 64'(ec));
    chk("os_ovf", 64'(oo[i]), 64'(eo));
  endtask

  task automatic drain(input int i);
    int g = 0;
    ordy[i] = 1'b1;
    iv[i]   = 1'b0;
    while (expq[i].size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("drain_empty", 64'(expq[i].size()), 64'd0);
    @(negedge clk);
    chk("drain_idle", 64'(ov[i]), 64'd0);
  endtask

  task automatic stream(input int i, input int n, input int rdy_pct, input int vld_pct);
    int  sent = 0;
    int  guard = 0;
    int  cycles = 0;
    logic acc;
    @(posedge clk); #1;
    new_data(i);
    iv[i] = 1'b1;
    while (sent < n && guard < 5000) begin
      ordy[i] = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      acc = iv[i] && ir[i];
      @(posedge clk); #1;
      guard++;
      cycles++;
      if (acc) begin
        sent++;
        new_data(i);
        iv[i] = ($urandom_range(99) < vld_pct);
      end else if (!iv[i]) begin
        iv[i] = ($urandom_range(99) < vld_pct);
      end
    end
    iv[i] = 1'b0;
    chk("stream_sent", 64'(sent), 64'(n));
    if (rdy_pct >= 100 && vld_pct >= 100) chk("tput_cycles", 64'(cycles), 64'(n));
    drain(i);
  endtask

  task automatic stall(input int i);
    int   acc_cnt = 0;
    logic acc;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    new_data(i);
    iv[i] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      acc = iv[i] && ir[i];
      if (acc) acc_cnt++;
      @(posedge clk); #1;
      if (acc) new_data(i);
    end
    chk("stall_acc", 64'(acc_cnt), 64'(sof(i)));
    @(negedge clk);
    chk("stall_rdy", 64'(ir[i]), 64'd0);
    drain(i);
  endtask

  initial begin
    logic cbit;
    int   seen;
    rst_n = 1'b0;
    iv = '0; ordy = '1; icin = '0; isub = '0; ia = '0; ib = '0;
    held = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_vld", 64'(ov[i]), 64'd0);
      chk("rst_sum", 64'(obs(i) & 34'hFFFFFFFF), 64'd0);
      chk("rst_cout", 64'(oc[i]), 64'd0);
      chk("rst_ovf", 64'(oo[i]), 64'd0);
      chk("rst_rdy", 64'(ir[i]), 64'd1);
    end

    for (int i = 1; i < 3; i++) begin
      one_shot(i, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
      one_shot(i, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
      one_shot(i, 32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b1, 1'b0);
      one_shot(i, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b0, 1'b1);
    end

    // 64-bit add as two chained 32-bit beats.
    one_shot(0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cbit = oc[0];
    one_shot(0, 32'h00000001, 32'h0, cbit, 1'b0, 32'h2, 1'b0, 1'b0);
    drain(0);

    stream(0, 100, 50, 75);
    stream(1, 40, 50, 75);
    stream(2, 40, 50, 75);
    stream(0, 20, 100, 100);
    stream(2, 20, 100, 100);

    for (int i = 0; i < 3; i++) stall(i);

    // Reset with the 32/4 pipe full and stalled.
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    ia[0] = 32'h12345678; ib[0] = 32'h9ABCDEF0; icin[0] = 1'b1; isub[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (8) @(posedge clk);
    #1 iv[0] = 1'b0;
    chk("pre_rst_vld", 64'(ov[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(ov[0]), 64'd0);
    chk("arst_sum", 64'(os0), 64'd0);
    chk("arst_cout", 64'(oc[0]), 64'd0);
    chk("arst_ovf", 64'(oo[0]), 64'd0);
    for (int i = 0; i < 3; i++) expq[i].delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("post_rst_vld", 64'(seen), 64'd0);
    chk("post_rst_rdy", 64'(ir[0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
